// File: rtl/sdc_pkg.sv
// Shared types and defaults for the SD controller register-write path.
package sdc_pkg;

  localparam int NUM_BYTES_DEF = 4;
  localparam int BYTE_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One requester word together with its byte-enable mask.
  typedef struct packed {
    logic [NUM_BYTES_DEF*BYTE_W_DEF-1:0] data;
    logic [NUM_BYTES_DEF-1:0]            be;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advanced on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_prio_one;
  logic w_pick_one;

  // Requester 1 wins when alone, or when both ask and it holds priority.
  assign w_pick_one = i_req[1] & (~i_req[0] | r_prio_one);
  assign o_grant    = {i_req[1] & w_pick_one, i_req[0] & ~w_pick_one};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio_one <= 1'b0;
    end else if (i_accept) begin
      r_prio_one <= ~w_pick_one;
    end
  end

endmodule

// File: rtl/byte_reg_write_arbiter.sv
// Arbitrates two word requesters and serialises each accepted word into
// single-byte register writes, lowest enabled byte first.
module byte_reg_write_arbiter
  import sdc_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int BYTE_W    = BYTE_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [NUM_BYTES*BYTE_W-1:0]   req0_data,
  input  logic [NUM_BYTES-1:0]          req0_be,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [NUM_BYTES*BYTE_W-1:0]   req1_data,
  input  logic [NUM_BYTES-1:0]          req1_be,
  output logic                          req1_ready,
  output logic                          reg_we,
  output logic [$clog2(NUM_BYTES)-1:0]  reg_byte_sel,
  output logic [BYTE_W-1:0]             reg_d_byte,
  output logic                          busy,
  output logic                          grant_id,
  output logic                          done
);

  localparam int SEL_W  = $clog2(NUM_BYTES);
  localparam int WORD_W = NUM_BYTES * BYTE_W;

  state_t                r_state;
  logic [WORD_W-1:0]     r_data;
  logic [NUM_BYTES-1:0]  r_mask;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [BYTE_W-1:0]     r_d;
  logic                  r_busy;
  logic                  r_grant_id;
  logic                  r_done;

  logic [1:0]            w_grant;
  logic                  w_idle;
  logic                  w_accept;
  logic [WORD_W-1:0]     w_scan_data;
  logic [NUM_BYTES-1:0]  w_scan_mask;
  logic [SEL_W-1:0]      w_low_idx;
  logic [NUM_BYTES-1:0]  w_low_bit;
  logic [BYTE_W-1:0]     w_low_byte;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({req1_valid, req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign req0_ready = w_idle & w_grant[0];
  assign req1_ready = w_idle & w_grant[1];
  assign w_accept   = req0_ready | req1_ready;

  // In IDLE the scan looks at the incoming winner; otherwise at what is left to write.
  assign w_scan_data = w_idle ? (w_grant[1] ? req1_data : req0_data) : r_data;
  assign w_scan_mask = w_idle ? (w_grant[1] ? req1_be   : req0_be)   : r_mask;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_low_idx = '0;
    w_low_bit = '0;
    for (int i = NUM_BYTES - 1; i >= 0; i--) begin
      if (w_scan_mask[i]) begin
        w_low_idx    = SEL_W'(i);
        w_low_bit    = '0;
        w_low_bit[i] = 1'b1;
      end
    end
  end

  assign w_low_byte = w_scan_data[int'(w_low_idx)*BYTE_W +: BYTE_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_mask     <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_d        <= '0;
      r_busy     <= 1'b0;
      r_grant_id <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data     <= w_scan_data;
            r_grant_id <= w_grant[1];
            r_busy     <= 1'b1;
            if (|w_scan_mask) begin
              r_we    <= 1'b1;
              r_sel   <= w_low_idx;
              r_d     <= w_low_byte;
              r_mask  <= w_scan_mask & ~w_low_bit;
              r_state <= ST_WRITE;
            end else begin
              r_mask  <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (|r_mask) begin
            r_sel  <= w_low_idx;
            r_d    <= w_low_byte;
            r_mask <= r_mask & ~w_low_bit;
          end else begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reg_we       = r_we;
  assign reg_byte_sel = r_sel;
  assign reg_d_byte   = r_d;
  assign busy         = r_busy;
  assign grant_id     = r_grant_id;
  assign done         = r_done;

endmodule

// File: tb/tb_byte_reg_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration order and byte sequencing.
module tb_byte_reg_write_arbiter;
  import sdc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [3:0]  req0_be, req1_be;
  logic        reg_we;
  logic [1:0]  reg_byte_sel;
  logic [7:0]  reg_d_byte;
  logic        busy, grant_id, done;

  req_t rq0, rq1;
  assign req0_data = rq0.data;
  assign req0_be   = rq0.be;
  assign req1_data = rq1.data;
  assign req1_be   = rq1.be;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: who was granted last, and the last written byte lane/value.
  logic       last_g;
  logic [1:0] last_sel;
  logic [7:0] last_d;

  byte_reg_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_be      (req0_be),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_be      (req1_be),
    .req1_ready   (req1_ready),
    .reg_we       (reg_we),
    .reg_byte_sel (reg_byte_sel),
    .reg_d_byte   (reg_d_byte),
    .busy         (busy),
    .grant_id     (grant_id),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    chk("rst_we",    32'(reg_we),       0);
    chk("rst_sel",   32'(reg_byte_sel), 0);
    chk("rst_d",     32'(reg_d_byte),   0);
    chk("rst_busy",  32'(busy),         0);
    chk("rst_gid",   32'(grant_id),     0);
    chk("rst_done",  32'(done),         0);
    chk("rst_rdy",   32'({req1_ready, req0_ready}), 0);
    rst      = 1'b1;
    last_g   = 1'b1;
    last_sel = '0;
    last_d   = '0;
  endtask

  // Expects requester id to win now (or within a bounded wait) and checks the whole transaction.
  task automatic expect_txn(input logic id, input bit drop);
    req_t r;
    int   waited = 0;
    r = id ? rq1 : rq0;
    #1;
    while (!(id ? req1_ready : req0_ready) && waited < 20) begin
      step();
      waited++;
    end
    chk("ready_win",  32'(id ? req1_ready : req0_ready), 1);
    chk("ready_lose", 32'(id ? req0_ready : req1_ready), 0);
    last_g = id;
    step();
    if (drop) begin
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (r.be[i]) begin
        chk("wr_we",   32'(reg_we),       1);
        chk("wr_sel",  32'(reg_byte_sel), i);
        chk("wr_d",    32'(reg_d_byte),   32'(r.data[8*i +: 8]));
        chk("wr_busy", 32'(busy),         1);
        chk("wr_done", 32'(done),         0);
        chk("wr_gid",  32'(grant_id),     32'(id));
        chk("wr_rdy",  32'({req1_ready, req0_ready}), 0);
        last_sel = 2'(i);
        last_d   = r.data[8*i +: 8];
        step();
      end
    end
    chk("dn_done", 32'(done),         1);
    chk("dn_we",   32'(reg_we),       0);
    chk("dn_busy", 32'(busy),         1);
    chk("dn_sel",  32'(reg_byte_sel), 32'(last_sel));
    chk("dn_d",    32'(reg_d_byte),   32'(last_d));
    chk("dn_gid",  32'(grant_id),     32'(id));
    chk("dn_rdy",  32'({req1_ready, req0_ready}), 0);
    step();
    chk("post_done", 32'(done),     0);
    chk("post_busy", 32'(busy),     0);
    chk("post_gid",  32'(grant_id), 32'(id));
  endtask

  initial begin
    logic w;
    rq0 = '0;
    rq1 = '0;

    // Single request
    do_reset();
    rq0 = '{data: 32'hA1B2C3D4, be: 4'b0101};
    req0_valid = 1'b1;
    expect_txn(1'b0, 1'b1);

    // Contention from reset
    do_reset();
    rq0 = '{data: 32'h11223344, be: 4'hF};
    rq1 = '{data: 32'h55667788, be: 4'h1};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    expect_txn(1'b0, 1'b1);
    expect_txn(1'b1, 1'b1);

    // Fairness: both continuously valid, grants must alternate 0,1,0,1
    rq0 = '{data: $urandom, be: 4'h1};
    rq1 = '{data: $urandom, be: 4'h1};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_txn(1'(i % 2), 1'b0);
      if (i % 2 == 0) rq0.data = $urandom;
      else            rq1.data = $urandom;
    end

    // Empty mask on requester 1
    req0_valid = 1'b0;
    rq1 = '{data: 32'hCAFEF00D, be: 4'b0000};
    expect_txn(1'b1, 1'b1);

    // Sparse mask: only the top byte
    rq0 = '{data: 32'hDEADBEEF, be: 4'b1000};
    req0_valid = 1'b1;
    expect_txn(1'b0, 1'b1);

    // Randomized traffic; the loser of each round stays pending untouched
    for (int t = 0; t < 24; t++) begin
      if (!req0_valid && ($urandom_range(0, 1) == 1)) begin
        rq0.data = $urandom;
        rq0.be   = 4'($urandom_range(0, 15));
        req0_valid = 1'b1;
      end
      if (!req1_valid && ($urandom_range(0, 1) == 1)) begin
        rq1.data = $urandom;
        rq1.be   = 4'($urandom_range(0, 15));
        req1_valid = 1'b1;
      end
      if (!req0_valid && !req1_valid) begin
        rq0.data = $urandom;
        rq0.be   = 4'($urandom_range(0, 15));
        req0_valid = 1'b1;
      end
      w = (req0_valid && req1_valid) ? ~last_g : req1_valid;
      expect_txn(w, 1'b1);
    end

    // Reset during the second write of a full-mask transaction from requester 0
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rq0 = '{data: 32'h0BADF00D, be: 4'hF};
    req0_valid = 1'b1;
    #1;
    chk("mid_ready", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    chk("mid_wr0", 32'({reg_we, reg_byte_sel}), 32'({1'b1, 2'd0}));
    step();
    chk("mid_wr1", 32'({reg_we, reg_byte_sel}), 32'({1'b1, 2'd1}));
    rst = 1'b0;
    step();
    chk("mid_we",   32'(reg_we), 0);
    chk("mid_busy", 32'(busy),   0);
    chk("mid_done", 32'(done),   0);
    step();
    chk("mid_done2", 32'(done),         0);
    chk("mid_sel",   32'(reg_byte_sel), 0);
    rst      = 1'b1;
    last_g   = 1'b1;
    last_sel = '0;
    last_d   = '0;
    step();
    chk("mid_done3", 32'(done), 0);
    chk("mid_we3",   32'(reg_we), 0);

    // After reset both contend; pointer must favour requester 0 again
    rq0 = '{data: 32'h13579BDF, be: 4'b0110};
    rq1 = '{data: 32'h2468ACE0, be: 4'b1001};
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    expect_txn(1'b0, 1'b1);
    expect_txn(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
